// File: rtl/dl_sequencer.sv
// Download/reset sequencer: routes ioctl bytes to ROM, title number and DIP
// registers, and holds the game core in reset until a download has settled.
module dl_sequencer #(
    parameter int ROM_SIZE = 131072,
    parameter int POST_RST = 16
) (
    input  logic        clk_sys,
    input  logic        RESET,
    input  logic        usr_rst,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [7:0]  ioctl_index,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        rom_we,
    output logic [23:0] rom_addr,
    output logic [7:0]  rom_dout,
    output logic [3:0]  tno,
    output logic [23:0] dsw,
    output logic        core_rst,
    output logic        busy,
    output logic        dl_err
);
    typedef enum logic [1:0] {LOAD, HOLD, RUN} state_t;

    localparam logic [7:0]  HOLD_CNT  = 8'(POST_RST);
    localparam logic [24:0] ROM_BYTES = 25'(ROM_SIZE);

    state_t      state;
    logic [7:0]  cnt;
    logic [24:0] wcnt;
    logic        seen0;

    logic wr_ok, wr_rom, wr_bad, load_entry, load_exit;
    assign wr_ok      = ioctl_wr & ioctl_download;
    assign wr_rom     = wr_ok && (ioctl_index == 8'd0);
    assign wr_bad     = wr_rom && (ioctl_addr >= ROM_BYTES);
    assign load_entry = ioctl_download && (state != LOAD);
    assign load_exit  = !ioctl_download && (state == LOAD);

    // core_rst/busy are updated together with state so they always mirror it.
    always_ff @(posedge clk_sys) begin
        if (RESET) begin
            state    <= HOLD;
            cnt      <= HOLD_CNT;
            core_rst <= 1'b1;
            busy     <= 1'b1;
        end else if (ioctl_download) begin
            state    <= LOAD;
            core_rst <= 1'b1;
            busy     <= 1'b1;
        end else begin
            case (state)
                LOAD: begin
                    state <= HOLD;
                    cnt   <= HOLD_CNT;
                end
                HOLD: begin
                    if (usr_rst) begin
                        cnt <= HOLD_CNT;
                    end else if (cnt == 8'd1) begin
                        state    <= RUN;
                        core_rst <= 1'b0;
                        busy     <= 1'b0;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                RUN: begin
                    if (usr_rst) begin
                        state    <= HOLD;
                        cnt      <= HOLD_CNT;
                        core_rst <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                default: begin
                    state    <= HOLD;
                    cnt      <= HOLD_CNT;
                    core_rst <= 1'b1;
                    busy     <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk_sys) begin
        if (RESET) begin
            rom_we   <= 1'b0;
            rom_addr <= '0;
            rom_dout <= '0;
            tno      <= '0;
            dsw      <= '0;
            dl_err   <= 1'b0;
            wcnt     <= '0;
            seen0    <= 1'b0;
        end else begin
            rom_we <= 1'b0;
            if (wr_rom && !wr_bad) begin
                rom_we   <= 1'b1;
                rom_addr <= ioctl_addr[23:0];
                rom_dout <= ioctl_dout;
            end
            if (wr_ok && ioctl_index == 8'd1)
                tno <= ioctl_dout[3:0];
            if (wr_ok && ioctl_index == 8'd254) begin
                case (ioctl_addr)
                    25'd0:   dsw[7:0]   <= ioctl_dout;
                    25'd1:   dsw[15:8]  <= ioctl_dout;
                    25'd2:   dsw[23:16] <= ioctl_dout;
                    default: ;
                endcase
            end

            // Write count covers dropped bytes too, so an oversized image is caught twice.
            if (load_entry) begin
                wcnt  <= wr_rom ? 25'd1 : 25'd0;
                seen0 <= wr_rom;
            end else if (wr_rom) begin
                if (wcnt != '1)
                    wcnt <= wcnt + 25'd1;
                seen0 <= 1'b1;
            end

            // The first index-0 byte of a download starts a fresh error verdict.
            if (wr_rom)
                dl_err <= wr_bad | (dl_err & seen0 & !load_entry);
            else if (load_exit && seen0 && wcnt != ROM_BYTES)
                dl_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_dl_sequencer.sv
// Bench for dl_sequencer: directed download/reset scenarios with random data,
// checked every cycle against a transaction-level model of the outputs.
module tb_dl_sequencer;
    localparam int ROM = 16384;
    localparam int PR  = 16;

    logic        clk_sys = 1'b0;
    logic        RESET = 1'b1;
    logic        usr_rst = 1'b0;
    logic        ioctl_download = 1'b0;
    logic        ioctl_wr = 1'b0;
    logic [7:0]  ioctl_index = '0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = '0;
    logic        rom_we;
    logic [23:0] rom_addr;
    logic [7:0]  rom_dout;
    logic [3:0]  tno;
    logic [23:0] dsw;
    logic        core_rst;
    logic        busy;
    logic        dl_err;

    dl_sequencer #(.ROM_SIZE(ROM), .POST_RST(PR)) dut (
        .clk_sys(clk_sys), .RESET(RESET), .usr_rst(usr_rst),
        .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
        .ioctl_index(ioctl_index), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .rom_we(rom_we), .rom_addr(rom_addr), .rom_dout(rom_dout),
        .tno(tno), .dsw(dsw), .core_rst(core_rst), .busy(busy), .dl_err(dl_err)
    );

    always #5 clk_sys = ~clk_sys;

    int total = 0;
    int bad = 0;
    int nwe = 0;

    // Model of what the outputs should show after the next edge.
    logic        exp_we = 1'b0;
    logic [23:0] m_addr = '0;
    logic [7:0]  m_dout = '0;
    logic [3:0]  m_tno = '0;
    logic [23:0] m_dsw = '0;
    logic        m_err = 1'b0;
    logic        m_seen0 = 1'b0;
    int          m_wcnt = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic void model_reset();
        exp_we = 1'b0; m_addr = '0; m_dout = '0; m_tno = '0; m_dsw = '0;
        m_err = 1'b0; m_seen0 = 1'b0; m_wcnt = 0;
    endfunction

    task automatic tick();
        @(posedge clk_sys);
        #1;
        chk("rom_we", 32'(rom_we), 32'(exp_we));
        chk("rom_addr", 32'(rom_addr), 32'(m_addr));
        chk("rom_dout", 32'(rom_dout), 32'(m_dout));
        chk("tno", 32'(tno), 32'(m_tno));
        chk("dsw", 32'(dsw), 32'(m_dsw));
        chk("dl_err", 32'(dl_err), 32'(m_err));
        if (rom_we === 1'b1) nwe++;
        exp_we = 1'b0;
    endtask

    task automatic wr(input logic [7:0] idx, input logic [24:0] a, input logic [7:0] d);
        ioctl_wr = 1'b1; ioctl_index = idx; ioctl_addr = a; ioctl_dout = d;
        if (ioctl_download && !RESET) begin
            if (idx == 8'd0) begin
                if (!m_seen0) m_err = 1'b0;
                m_seen0 = 1'b1;
                m_wcnt++;
                if (a < ROM) begin
                    exp_we = 1'b1; m_addr = a[23:0]; m_dout = d;
                end else begin
                    m_err = 1'b1;
                end
            end else if (idx == 8'd1) begin
                m_tno = d[3:0];
            end else if (idx == 8'd254 && a < 3) begin
                m_dsw[int'(a)*8 +: 8] = d;
            end
        end
        tick();
        ioctl_wr = 1'b0;
    endtask

    // Counts cycles with core_rst high, starting from the current sample.
    task automatic measure(input string tag, input int want);
        int n = 0;
        for (int k = 0; k < 1000 && core_rst === 1'b1; k++) begin
            chk("busy_hi", 32'(busy), 32'd1);
            n++;
            tick();
        end
        chk(tag, n, want);
        chk("core_rst_lo", 32'(core_rst), 32'd0);
        chk("busy_lo", 32'(busy), 32'd0);
    endtask

    task automatic dl_start();
        ioctl_download = 1'b1;
        m_seen0 = 1'b0; m_wcnt = 0;
        tick();
    endtask

    task automatic dl_end(input string tag);
        ioctl_download = 1'b0;
        if (m_seen0 && m_wcnt != ROM) m_err = 1'b1;
        tick();
        measure(tag, PR);
    endtask

    initial begin
        int base;
        int n;

        // Power-on reset and release timing
        model_reset();
        repeat (3) tick();
        chk("rst_core_rst", 32'(core_rst), 32'd1);
        chk("rst_busy", 32'(busy), 32'd1);
        RESET = 1'b0;
        measure("hold_after_reset", PR);

        // Strobe without download is ignored
        wr(8'd0, 25'd5, 8'h55);
        tick();

        // DIP and title bytes
        dl_start();
        wr(8'd254, 25'd0, 8'hA1);
        wr(8'd254, 25'd1, 8'hB2);
        wr(8'd254, 25'd2, 8'hC3);
        wr(8'd254, 25'd3, 8'hFF);
        wr(8'd254, 25'd9, 8'(($urandom_range(0, 255))));
        wr(8'd7,   25'd0, 8'h42);
        wr(8'd1,   25'd0, 8'h15);
        wr(8'd1,   25'd0, 8'h13);
        dl_end("hold_after_dip");
        chk("dsw_value", 32'(dsw), 32'h00C3B2A1);
        chk("tno_value", 32'(tno), 32'd3);

        // Oversized ROM image
        base = nwe;
        dl_start();
        for (int i = 0; i <= ROM; i++) wr(8'd0, 25'(i), 8'($urandom_range(0, 255)));
        dl_end("hold_after_oversize");
        chk("oversize_pulses", nwe - base, ROM);
        chk("oversize_err", 32'(dl_err), 32'd1);
        repeat (5) tick();

        // Title-only download leaves the error flag alone
        dl_start();
        wr(8'd1, 25'd0, 8'($urandom_range(0, 255)));
        dl_end("hold_after_title");
        chk("err_kept", 32'(dl_err), 32'd1);

        // Correct ROM image clears the error
        base = nwe;
        dl_start();
        for (int i = 0; i < ROM; i++) wr(8'd0, 25'(i), 8'($urandom_range(0, 255)));
        dl_end("hold_after_rom");
        chk("rom_pulses", nwe - base, ROM);
        chk("rom_err_clear", 32'(dl_err), 32'd0);

        // Short image flags an error
        dl_start();
        for (int i = 0; i < 100; i++) wr(8'd0, 25'($urandom_range(0, ROM - 1)), 8'($urandom_range(0, 255)));
        dl_end("hold_after_short");
        chk("short_err", 32'(dl_err), 32'd1);

        // usr_rst held 5 cycles in RUN
        usr_rst = 1'b1;
        n = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (core_rst === 1'b1) n++;
        end
        usr_rst = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            tick();
            if (core_rst !== 1'b1) break;
            n++;
        end
        chk("usr_rst_hold", n, 5 + PR - 1);

        // Download wins over usr_rst
        usr_rst = 1'b1;
        dl_start();
        repeat (30) tick();
        chk("dl_prio_core_rst", 32'(core_rst), 32'd1);
        usr_rst = 1'b0;
        dl_end("hold_after_prio");

        // Reset in the middle of a download
        dl_start();
        for (int i = 0; i < 1000; i++) wr(8'd0, 25'(i), 8'($urandom_range(0, 255)));
        RESET = 1'b1;
        model_reset();
        wr(8'd0, 25'd1000, 8'h5A);
        chk("midrst_core_rst", 32'(core_rst), 32'd1);
        chk("midrst_busy", 32'(busy), 32'd1);
        ioctl_download = 1'b0;
        tick();
        RESET = 1'b0;
        measure("hold_after_midrst", PR);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
